// File: rtl/mem_access_stage.sv
// MEM stage: turns load/store requests into a word-aligned data-memory handshake,
// stalls until memory answers, then formats load data for MEM/WB.
module mem_access_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread_in,
  input  logic        memwrite_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] rs2_data_in,
  input  logic        regwrite_in,
  input  logic [4:0]  rd_in,
  output logic        regwrite_MEM,
  output logic [4:0]  rd_MEM,
  output logic [31:0] rd_data_MEM,
  output logic        stall_MEM,
  output logic        mem_fault_MEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [1:0]  dbg_state
);

  // Handshake: dmem_req rises on the edge entering REQ and holds, with every request
  // field stable, until the first cycle dmem_ready=1; that cycle completes the transfer.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  state_t      r_state;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic        r_regwrite;
  logic [31:0] r_load_buf;

  logic        w_mem_op;
  logic        w_undef;
  logic        w_misalign;
  logic        w_fault;
  logic        w_start;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_mem_op = memread_in | memwrite_in;

  always_comb begin
    w_undef = 1'b0;
    if (memread_in && memwrite_in)
      w_undef = 1'b1;
    else if (memread_in)
      w_undef = !(funct3_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else if (memwrite_in)
      w_undef = !(funct3_in inside {3'b000, 3'b001, 3'b010});
  end

  assign w_misalign = ((funct3_in[1:0] == 2'b01) && alu_result_in[0]) ||
                      ((funct3_in[1:0] == 2'b10) && (alu_result_in[1:0] != 2'b00));
  assign w_fault    = w_mem_op && (w_undef || w_misalign);
  assign w_start    = (r_state == IDLE) && w_mem_op && !w_fault;

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = rs2_data_in;
    if (memwrite_in) begin
      case (funct3_in[1:0])
        2'b00: begin
          w_be    = 4'b0001 << alu_result_in[1:0];
          w_wdata = {4{rs2_data_in[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << alu_result_in[1:0];
          w_wdata = {2{rs2_data_in[15:0]}};
        end
        default: w_be = 4'b1111;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 32'd0;
      r_be       <= 4'd0;
      r_wdata    <= 32'd0;
      r_funct3   <= 3'd0;
      r_addr_lo  <= 2'd0;
      r_regwrite <= 1'b0;
      r_load_buf <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state    <= REQ;
            r_req      <= 1'b1;
            r_we       <= memwrite_in;
            r_addr     <= {alu_result_in[31:2], 2'b00};
            r_be       <= w_be;
            r_wdata    <= w_wdata;
            r_funct3   <= funct3_in;
            r_addr_lo  <= alu_result_in[1:0];
            r_regwrite <= regwrite_in & memread_in;
          end
        end
        REQ: begin
          if (dmem_ready) begin
            r_load_buf <= dmem_rdata;
            r_req      <= 1'b0;
            r_state    <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Load formatting works purely from the latched funct3/offset and the captured word.
  always_comb begin
    case (r_addr_lo)
      2'b00:   w_byte = r_load_buf[7:0];
      2'b01:   w_byte = r_load_buf[15:8];
      2'b10:   w_byte = r_load_buf[23:16];
      default: w_byte = r_load_buf[31:24];
    endcase
    w_half = r_addr_lo[1] ? r_load_buf[31:16] : r_load_buf[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = r_load_buf;
    endcase
  end

  always_comb begin
    regwrite_MEM = 1'b0;
    if (!reset) begin
      if (r_state == DONE)
        regwrite_MEM = r_regwrite;
      else if (r_state == IDLE && !w_mem_op)
        regwrite_MEM = regwrite_in;
    end
  end

  assign stall_MEM     = !reset && (w_start || (r_state == REQ));
  assign mem_fault_MEM = !reset && (r_state == IDLE) && w_fault;
  assign rd_data_MEM   = ((r_state == DONE) && !r_we) ? w_load : alu_result_in;
  assign rd_MEM        = rd_in;
  assign dmem_req      = r_req;
  assign dmem_we       = r_we;
  assign dmem_addr     = r_addr;
  assign dmem_be       = r_be;
  assign dmem_wdata    = r_wdata;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: scenario tasks plus a scoreboard of
// expected retire data.
module tb_mem_access_stage;

  logic        clk;
  logic        reset;
  logic        memread_in;
  logic        memwrite_in;
  logic [2:0]  funct3_in;
  logic [31:0] alu_result_in;
  logic [31:0] rs2_data_in;
  logic        regwrite_in;
  logic [4:0]  rd_in;
  logic        regwrite_MEM;
  logic [4:0]  rd_MEM;
  logic [31:0] rd_data_MEM;
  logic        stall_MEM;
  logic        mem_fault_MEM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  mem_access_stage dut (
    .clk(clk), .reset(reset), .memread_in(memread_in), .memwrite_in(memwrite_in),
    .funct3_in(funct3_in), .alu_result_in(alu_result_in), .rs2_data_in(rs2_data_in),
    .regwrite_in(regwrite_in), .rd_in(rd_in), .regwrite_MEM(regwrite_MEM), .rd_MEM(rd_MEM),
    .rd_data_MEM(rd_data_MEM), .stall_MEM(stall_MEM), .mem_fault_MEM(mem_fault_MEM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*off +: 8];
    h = word[16*off[1] +: 16];
    case (f3)
      3'b000:  return 32'($signed(b));
      3'b001:  return 32'($signed(h));
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  task automatic go_idle();
    memread_in = 0; memwrite_in = 0; funct3_in = 0; alu_result_in = 0;
    rs2_data_in = 0; regwrite_in = 0; rd_in = 0; dmem_ready = 0; dmem_rdata = 0;
  endtask

  // driver: presents one memory op just after a rising edge and plays the memory
  // side, acknowledging on REQ cycle number 'waits' (0-based); records observations.
  task automatic run_mem_op(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd, input int waits,
                            input logic [31:0] rdata,
                            output int stalls, output int req_cycles,
                            output logic [31:0] a_addr, output logic a_we,
                            output logic [3:0] a_be, output logic [31:0] a_wdata,
                            output logic [31:0] r_data, output logic r_wen,
                            output logic req_at_done, output logic timed_out);
    memread_in = rd_op; memwrite_in = wr_op; funct3_in = f3; alu_result_in = addr;
    rs2_data_in = wd; regwrite_in = 1'b1; rd_in = 5'd9; dmem_ready = 0;
    stalls = 0; req_cycles = 0; timed_out = 1;
    a_addr = 0; a_we = 0; a_be = 0; a_wdata = 0; r_data = 0; r_wen = 0; req_at_done = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (dmem_req) begin
        if (req_cycles == 0) begin
          a_addr = dmem_addr; a_we = dmem_we; a_be = dmem_be; a_wdata = dmem_wdata;
        end
        dmem_ready = (req_cycles == waits);
        dmem_rdata = (req_cycles == waits) ? rdata : $urandom();
        req_cycles++;
      end else begin
        dmem_ready = 0;
      end
      if (stall_MEM) stalls++;
      else if (stalls > 0) begin
        r_data = rd_data_MEM; r_wen = regwrite_MEM; req_at_done = dmem_req;
        timed_out = 0;
        break;
      end
    end
    @(posedge clk); #1;
    go_idle();
  endtask

  task automatic test_reset();
    memread_in = 1; regwrite_in = 1; funct3_in = 3'b010; alu_result_in = 32'h40;
    reset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (stall_MEM !== 0 || regwrite_MEM !== 0 || mem_fault_MEM !== 0) begin
      bad++;
      $display("FAIL reset_outs: stall=%b regwrite=%b fault=%b want 0 0 0",
               stall_MEM, regwrite_MEM, mem_fault_MEM);
    end
    total++;
    if (dmem_req !== 0 || dmem_we !== 0 || dmem_be !== 0 || dmem_addr !== 0 ||
        dmem_wdata !== 0 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL reset_regs: req=%b we=%b be=%h addr=%h wdata=%h st=%0d want all 0",
               dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, dbg_state);
    end
    go_idle();
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic test_passthru();
    alu_result_in = 32'h1234_5678; regwrite_in = 1; rd_in = 5'd7;
    @(negedge clk);
    total++;
    if (rd_data_MEM !== 32'h1234_5678 || regwrite_MEM !== 1 || rd_MEM !== 5'd7 ||
        stall_MEM !== 0 || dmem_req !== 0 || mem_fault_MEM !== 0) begin
      bad++;
      $display("FAIL passthru: data=%h we=%b rd=%0d stall=%b req=%b fault=%b want 12345678 1 7 0 0 0",
               rd_data_MEM, regwrite_MEM, rd_MEM, stall_MEM, dmem_req, mem_fault_MEM);
    end
    @(posedge clk); #1;
    go_idle();
  endtask

  task automatic test_lb_wait();
    int st, rq; logic [31:0] aa, aw, rdv; logic awe, rwe, rad, to; logic [3:0] abe;
    logic [31:0] exp;
    exp_q.push_back(32'hFFFF_FF80);
    run_mem_op(1, 0, 3'b000, 32'h103, 32'h0, 2, 32'h80FF_0000,
               st, rq, aa, awe, abe, aw, rdv, rwe, rad, to);
    exp = exp_q.pop_front();
    total++;
    if (to || st != 4 || rq != 3 || aa !== 32'h100 || awe !== 0 || abe !== 4'h0) begin
      bad++;
      $display("FAIL lb_wait_req: to=%b stalls=%0d reqs=%0d addr=%h we=%b be=%h want 0 4 3 100 0 0",
               to, st, rq, aa, awe, abe);
    end
    total++;
    if (rdv !== exp || rwe !== 1 || rad !== 0) begin
      bad++;
      $display("FAIL lb_wait_data: data=%h we=%b req=%b want %h 1 0", rdv, rwe, rad, exp);
    end
  endtask

  task automatic test_lhu();
    int st, rq; logic [31:0] aa, aw, rdv; logic awe, rwe, rad, to; logic [3:0] abe;
    logic [31:0] exp;
    exp_q.push_back(32'h0000_BEEF);
    run_mem_op(1, 0, 3'b101, 32'h102, 32'h0, 0, 32'hBEEF_1234,
               st, rq, aa, awe, abe, aw, rdv, rwe, rad, to);
    exp = exp_q.pop_front();
    total++;
    if (to || st != 2 || rq != 1 || aa !== 32'h100 || rdv !== exp || rwe !== 1) begin
      bad++;
      $display("FAIL lhu: to=%b stalls=%0d reqs=%0d addr=%h data=%h we=%b want 0 2 1 100 %h 1",
               to, st, rq, aa, rdv, rwe, exp);
    end
  endtask

  task automatic test_sb();
    int st, rq; logic [31:0] aa, aw, rdv; logic awe, rwe, rad, to; logic [3:0] abe;
    run_mem_op(0, 1, 3'b000, 32'h201, 32'hAABB_CCDD, 1, 32'h0,
               st, rq, aa, awe, abe, aw, rdv, rwe, rad, to);
    total++;
    if (to || st != 3 || rq != 2 || aa !== 32'h200 || awe !== 1 || abe !== 4'b0010 ||
        aw !== 32'hDDDD_DDDD || rwe !== 0) begin
      bad++;
      $display("FAIL sb: to=%b stalls=%0d reqs=%0d addr=%h we=%b be=%b wdata=%h regwr=%b want 0 3 2 200 1 0010 dddddddd 0",
               to, st, rq, aa, awe, abe, aw, rwe);
    end
  endtask

  task automatic test_sh_sw();
    int st, rq; logic [31:0] aa, aw, rdv; logic awe, rwe, rad, to; logic [3:0] abe;
    run_mem_op(0, 1, 3'b001, 32'h2A2, 32'h1122_3344, 0, 32'h0,
               st, rq, aa, awe, abe, aw, rdv, rwe, rad, to);
    total++;
    if (to || aa !== 32'h2A0 || abe !== 4'b1100 || aw !== 32'h3344_3344 || rwe !== 0) begin
      bad++;
      $display("FAIL sh: to=%b addr=%h be=%b wdata=%h regwr=%b want 0 2a0 1100 33443344 0",
               to, aa, abe, aw, rwe);
    end
    run_mem_op(0, 1, 3'b010, 32'h2B4, 32'hCAFE_F00D, 0, 32'h0,
               st, rq, aa, awe, abe, aw, rdv, rwe, rad, to);
    total++;
    if (to || aa !== 32'h2B4 || abe !== 4'b1111 || aw !== 32'hCAFE_F00D || awe !== 1) begin
      bad++;
      $display("FAIL sw: to=%b addr=%h be=%b wdata=%h we=%b want 0 2b4 1111 cafef00d 1",
               to, aa, abe, aw, awe);
    end
  endtask

  task automatic test_faults();
    logic [2:0]  f3s[4]   = '{3'b010, 3'b001, 3'b011, 3'b010};
    logic [31:0] addrs[4] = '{32'h302, 32'h101, 32'h300, 32'h300};
    logic        rds[4]   = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic        wrs[4]   = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      memread_in = rds[i]; memwrite_in = wrs[i]; funct3_in = f3s[i];
      alu_result_in = addrs[i]; regwrite_in = 1; rs2_data_in = 32'h55;
      @(negedge clk);
      total++;
      if (mem_fault_MEM !== 1 || stall_MEM !== 0 || regwrite_MEM !== 0 || dmem_req !== 0) begin
        bad++;
        $display("FAIL fault_%0d: fault=%b stall=%b regwr=%b req=%b want 1 0 0 0",
                 i, mem_fault_MEM, stall_MEM, regwrite_MEM, dmem_req);
      end
      @(posedge clk); #1;
      go_idle();
      @(negedge clk);
      total++;
      if (mem_fault_MEM !== 0 || dmem_req !== 0 || dbg_state !== 2'd0) begin
        bad++;
        $display("FAIL fault_after_%0d: fault=%b req=%b st=%0d want 0 0 0",
                 i, mem_fault_MEM, dmem_req, dbg_state);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_in_req();
    int st, rq; logic [31:0] aa, aw, rdv; logic awe, rwe, rad, to; logic [3:0] abe;
    logic [31:0] exp;
    memread_in = 1; funct3_in = 3'b010; alu_result_in = 32'h40; regwrite_in = 1;
    dmem_ready = 0;
    @(negedge clk);            // IDLE, stalling
    @(negedge clk);            // REQ, first cycle
    @(negedge clk);            // REQ, second cycle
    total++;
    if (dmem_req !== 1 || stall_MEM !== 1) begin
      bad++;
      $display("FAIL rst_req_pre: req=%b stall=%b want 1 1", dmem_req, stall_MEM);
    end
    reset = 1;
    @(posedge clk); #1;
    total++;
    if (dmem_req !== 0 || stall_MEM !== 0 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL rst_req_abort: req=%b stall=%b st=%0d want 0 0 0",
               dmem_req, stall_MEM, dbg_state);
    end
    reset = 0;
    go_idle();
    @(negedge clk);
    total++;
    if (dmem_req !== 0 || stall_MEM !== 0) begin
      bad++;
      $display("FAIL rst_req_idle: req=%b stall=%b want 0 0", dmem_req, stall_MEM);
    end
    @(posedge clk); #1;
    exp_q.push_back(32'h0000_0001);
    run_mem_op(1, 0, 3'b010, 32'h0, 32'h0, 0, 32'h0000_0001,
               st, rq, aa, awe, abe, aw, rdv, rwe, rad, to);
    exp = exp_q.pop_front();
    total++;
    if (to || st != 2 || rq != 1 || aa !== 32'h0 || rdv !== exp || rwe !== 1) begin
      bad++;
      $display("FAIL rst_req_lw: to=%b stalls=%0d reqs=%0d addr=%h data=%h we=%b want 0 2 1 0 %h 1",
               to, st, rq, aa, rdv, rwe, exp);
    end
  endtask

  task automatic test_back_to_back();
    int st, rq; logic [31:0] aa, aw, rdv; logic awe, rwe, rad, to; logic [3:0] abe;
    logic [31:0] exp;
    logic [2:0]  f3s[6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000};
    for (int i = 0; i < 10; i++) begin
      logic [2:0]  f3;
      logic [31:0] addr, word;
      int          waits;
      f3    = f3s[$urandom_range(0, 5)];
      addr  = {$urandom_range(0, 32'hFFFF), 2'b00} << 4;
      addr[1:0] = (f3[1:0] == 2'b00) ? 2'($urandom_range(0, 3)) :
                  (f3[1:0] == 2'b01) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
      word  = $urandom();
      waits = $urandom_range(0, 3);
      exp_q.push_back(model_load(f3, addr[1:0], word));
      run_mem_op(1, 0, f3, addr, 32'h0, waits, word,
                 st, rq, aa, awe, abe, aw, rdv, rwe, rad, to);
      exp = exp_q.pop_front();
      total++;
      if (to || st != waits + 2 || rq != waits + 1 || aa !== {addr[31:2], 2'b00} ||
          rdv !== exp || rwe !== 1 || rad !== 0) begin
        bad++;
        $display("FAIL b2b_%0d: f3=%0d addr=%h to=%b stalls=%0d reqs=%0d daddr=%h data=%h we=%b want stalls=%0d data=%h",
                 i, f3, addr, to, st, rq, aa, rdv, rwe, waits + 2, exp);
      end
    end
  endtask

  initial begin
    go_idle();
    reset = 1;
    test_reset();
    test_passthru();
    test_lb_wait();
    test_lhu();
    test_sb();
    test_sh_sw();
    test_faults();
    test_reset_in_req();
    test_back_to_back();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left: %0d entries want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MEM) stage of the RISC-V pipeline, between the EX/MEM and MEM/WB pipeline registers. Converts load/store requests into a word-aligned data-memory handshake with byte enables. Stalls the pipeline until memory responds, then formats load data (sign/zero extension). Produces the `regwrite_MEM`/`rd_MEM`/`rd_data_MEM` triple consumed by MEM/WB.

## Interface
- No parameters; data width 32 and address width 32 are fixed.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `memread_in` in 1: load in MEM this cycle.
- `memwrite_in` in 1: store in MEM this cycle.
- `funct3_in` in 3: access size/sign (RV32I load/store encoding).
- `alu_result_in` in 32: effective address, or ALU result for non-memory ops.
- `rs2_data_in` in 32: store data.
- `regwrite_in` in 1: instruction writes rd.
- `rd_in` in 5: destination register.
- `regwrite_MEM` out 1: write enable to MEM/WB.
- `rd_MEM` out 5: equals `rd_in`.
- `rd_data_MEM` out 32: load result or `alu_result_in`.
- `stall_MEM` out 1: freeze PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB.
- `mem_fault_MEM` out 1: misaligned or undefined access; one-cycle pulse.
- `dmem_req` out 1: memory request, registered.
- `dmem_we` out 1: 1 = store.
- `dmem_addr` out 32: `{alu_result_in[31:2],2'b00}`.
- `dmem_be` out 4: byte enables for the store lanes.
- `dmem_wdata` out 32: store data replicated across lanes.
- `dmem_ready` in 1: request accepted/completed this cycle.
- `dmem_rdata` in 32: read word; valid when `dmem_ready`=1 on a load.

## Operation
- Non-memory op (`memread_in`=`memwrite_in`=0):
  - Pass-through with no stall.
  - `rd_data_MEM` = `alu_result_in`; `regwrite_MEM` = `regwrite_in`.
- Access check, for a memory op:
  - Loads accept 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores accept 000 SB, 001 SH, 010 SW.
  - Any other funct3 is undefined.
  - Misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠00.
- Faulting op:
  - `mem_fault_MEM`=1 and `regwrite_MEM`=0 for that cycle.
  - `stall_MEM`=0, no memory request, state stays IDLE.
- Both `memread_in` and `memwrite_in` set: undefined access, handled as a fault.
- State machine, states IDLE, REQ, DONE:
  - IDLE: a valid memory op sets `stall_MEM`=1 and moves to REQ. The request fields are latched at this point.
  - REQ: `dmem_req`=1, with `dmem_we`/`dmem_addr`/`dmem_be`/`dmem_wdata` held stable from the latch. `stall_MEM`=1.
  - REQ with `dmem_ready`=1: capture `dmem_rdata` into the load buffer, deassert `dmem_req` next cycle, move to DONE.
  - REQ with `dmem_ready`=0: stay in REQ.
  - DONE: `stall_MEM`=0 and the op retires into MEM/WB. Return to IDLE next cycle.
- `regwrite_MEM`:
  - Forced 0 while `stall_MEM`=1.
  - In DONE: `regwrite_in` for a load, 0 for a store.
- Byte enables: SB → `4'b0001<<addr[1:0]`; SH → `4'b0011<<addr[1:0]`; SW → `4'b1111`; loads → `4'b0000`.
- Store data: SB `{4{rs2[7:0]}}`, SH `{2{rs2[15:0]}}`, SW `rs2`.
- Load formatting in DONE:
  - Select byte `addr[1:0]` or halfword `addr[1]` from the buffer.
  - LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.

## Timing
- Reset values, applied on any rising edge with `reset`=1:
  - State IDLE; `dmem_req`=0, `dmem_we`=0, `dmem_be`=0.
  - `dmem_addr`=0, `dmem_wdata`=0, load buffer=0.
- While `reset`=1, `regwrite_MEM`=0, `stall_MEM`=0 and `mem_fault_MEM`=0. Other combinational outputs are don't-care.
- Latency with zero-wait memory (`dmem_ready`=1 on first REQ cycle):
  - Op arrives in cycle 0 (IDLE, stall).
  - Cycle 1: REQ, ready.
  - Cycle 2: DONE, retire.
  - Total: 2 stall cycles.
- Each wait cycle in REQ adds one stall cycle. There is no timeout.
- Upstream holds all `*_in` inputs constant while `stall_MEM`=1. The block relies only on its latched copy once in REQ.
- Exactly one `dmem_req` transaction per memory op. `dmem_req` never asserts in IDLE or DONE.
- Reset during REQ: abort to IDLE next edge and drop `dmem_req`. Memory discards an unacknowledged request.
- Back-to-back memory ops: the second op is seen in the IDLE cycle after DONE. There is no overlap.
- Fault detection and pass-through are combinational in the same cycle as input arrival.

## Test plan
- ALU pass-through: `alu_result_in`=0x1234_5678, `regwrite_in`=1, `rd_in`=7 → same cycle `rd_data_MEM`=0x1234_5678, `regwrite_MEM`=1, `stall_MEM`=0, no `dmem_req`.
- LB sign-extend, 2 wait states:
  - Stimulus: addr 0x103, `dmem_rdata`=0x80FF_0000, `dmem_ready` on 3rd REQ cycle.
  - Response: `dmem_addr`=0x100; 4 stall cycles; DONE shows `rd_data_MEM`=0xFFFF_FF80, `regwrite_MEM`=1.
- LHU at 0x102, rdata 0xBEEF_1234, zero-wait → `rd_data_MEM`=0x0000_BEEF after 2 stall cycles.
- SB to 0x201 with rs2=0xAABB_CCDD → `dmem_we`=1, `dmem_be`=0010, `dmem_wdata`=0xDDDD_DDDD, `regwrite_MEM`=0 at DONE.
- Misaligned SW to 0x302 → `mem_fault_MEM`=1 for one cycle, no `dmem_req`, `stall_MEM`=0, `regwrite_MEM`=0.
- Reset asserted on 2nd REQ cycle → next cycle IDLE, `dmem_req`=0, `stall_MEM`=0. A following LW at 0x0 with rdata 0x1 completes normally with `rd_data_MEM`=0x1.
